// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg
// Shared definitions for the CPU control blocks. It holds the opcodes of the
// supported ISA subset, the multi-cycle FSM state encoding, the datapath
// select codes, and the packed control-word struct driven by the decoder.
//
// Optional feature macro: MULTICYCLE_CONTROL_ADDI_EN adds the ADDI states
// and makes OP_ADDI a legal opcode.
package cpu_ctrl_pkg;

  // Opcodes, IR[31:26]
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  // ALUop codes
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // PCSource codes
  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  // ALUSrcB codes
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // Width of the encoding below; the top-level STATE_W must be at least this.
  localparam int STATE_ENC_W = 4;

  // Codes 10 and 11 stay reserved for ADDI even when the feature is off, so
  // the encoding of every other state does not move with the macro.
  typedef enum logic [STATE_ENC_W-1:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXE    = 4'd6,
    S_RWB    = 4'd7,
    S_BR     = 4'd8,
    S_JMP    = 4'd9
`ifdef MULTICYCLE_CONTROL_ADDI_EN
    ,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
`endif
  } state_t;

  // One cycle's worth of datapath control.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       reg_dst;
    logic       retire;
    logic       illegal_op;
  } ctrl_t;

  // True for every opcode the control FSM knows how to sequence.
  function automatic logic op_supported(input logic [5:0] op);
    logic ok;
    ok = (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
         (op == OP_BEQ) || (op == OP_J);
`ifdef MULTICYCLE_CONTROL_ADDI_EN
    ok = ok || (op == OP_ADDI);
`endif
    return ok;
  endfunction

endpackage

// File: rtl/multicycle_control_decode.sv
// multicycle_control_decode
// Combinational state-to-control decoder for the multi-cycle CPU control.
// The outputs are Moore (a function of state only), except for the IF
// IRWrite/PCWrite and MEMWR retire terms, which follow mem_ready, and the
// ID illegal_op flag, which follows op.
//
// Ports:
//   state     in   current FSM state (may hold an unused encoding)
//   op        in   opcode, used only for the illegal_op flag in ID
//   mem_ready in   effective memory-ready (already forced high when the
//                  handshake is disabled)
//   ctrl      out  control word for this cycle
//
// Optional feature macro: MULTICYCLE_CONTROL_ADDI_EN (ADDIEX/ADDIWB decode).
module multicycle_control_decode
  import cpu_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  // Everything defaults to 0, so each state lists only what it asserts and
  // unused encodings fall through to an all-zero control word.
  always_comb begin
    ctrl = '0;
    case (state)
      S_IF: begin
        ctrl.mem_read  = 1'b1;
        ctrl.i_or_d    = 1'b0;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCS_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_ID: begin
        // ALU precomputes the branch target while the opcode is decoded.
        ctrl.alu_src_a  = 1'b0;
        ctrl.alu_src_b  = SRCB_IMM_SH;
        ctrl.alu_op     = ALU_ADD;
        ctrl.illegal_op = ~op_supported(op);
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_dst    = 1'b0;
        ctrl.retire     = 1'b1;
      end
      S_MEMWR: begin
        // The store retires in whichever cycle memory accepts it.
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
        ctrl.retire    = mem_ready;
      end
      S_EXE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_RWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.mem_to_reg = 1'b0;
        ctrl.retire     = 1'b1;
      end
      S_BR: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCS_ALUOUT;
        ctrl.retire        = 1'b1;
      end
      S_JMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCS_JUMP;
        ctrl.retire    = 1'b1;
      end
`ifdef MULTICYCLE_CONTROL_ADDI_EN
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_ADDIWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b0;
        ctrl.retire     = 1'b1;
      end
`endif
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control
// Multi-cycle control FSM for a shared-memory, shared-ALU CPU datapath.
// Sequences R-type, LW, SW, BEQ and J through IF/ID/execute/memory/writeback
// and issues every datapath enable and mux select each cycle.
//
// Parameters:
//   MEM_HANDSHAKE  1: memory states wait for mem_ready; 0: mem_ready ignored
//   STATE_W        width of the debug state port (>= 4)
//
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   OP             opcode IR[31:26]
//   mem_ready      memory access complete this cycle
//   PCWrite .. RegDst   datapath enables and mux selects
//   retire         pulse in the final state of each instruction
//   illegal_op     pulse in ID for an unsupported opcode
//   state          current state, for debug
//
// Optional feature macro: MULTICYCLE_CONTROL_ADDI_EN adds ADDI support.
module multicycle_control
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_HANDSHAKE = 1,
  parameter int unsigned STATE_W       = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         OP,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic [1:0]         PCSource,
  output logic [1:0]         ALUop,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               RegWrite,
  output logic               RegDst,
  output logic               retire,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);

  state_t state_q;
  state_t state_d;
  logic   mem_rdy;
  ctrl_t  ctrl_raw;
  ctrl_t  ctrl;

  // With the handshake disabled every memory access completes in one cycle.
  assign mem_rdy = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

  // State register; reset aborts any instruction in flight and refetches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IF;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. mem_ready only matters in IF, MEMRD and MEMWR; any
  // unused encoding returns to IF through the default.
  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF:     state_d = mem_rdy ? S_ID : S_IF;
      S_ID: begin
        case (OP)
          OP_R:         state_d = S_EXE;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BR;
          OP_J:         state_d = S_JMP;
`ifdef MULTICYCLE_CONTROL_ADDI_EN
          OP_ADDI:      state_d = S_ADDIEX;
`endif
          default:      state_d = S_IF;
        endcase
      end
      S_MEMADR: state_d = (OP == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_rdy ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_IF;
      S_MEMWR:  state_d = mem_rdy ? S_IF : S_MEMWR;
      S_EXE:    state_d = S_RWB;
      S_RWB:    state_d = S_IF;
      S_BR:     state_d = S_IF;
      S_JMP:    state_d = S_IF;
`ifdef MULTICYCLE_CONTROL_ADDI_EN
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_IF;
`endif
      default:  state_d = S_IF;
    endcase
  end

  multicycle_control_decode u_decode (
    .state     (state_q),
    .op        (OP),
    .mem_ready (mem_rdy),
    .ctrl      (ctrl_raw)
  );

  // The state register already reads IF during reset, but IF itself drives
  // MemRead (and possibly PCWrite), so the control word is masked directly.
  always_comb begin
    ctrl = rst ? '0 : ctrl_raw;
  end

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.i_or_d;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign PCSource    = ctrl.pc_source;
  assign ALUop       = ctrl.alu_op;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign RegWrite    = ctrl.reg_write;
  assign RegDst      = ctrl.reg_dst;
  assign retire      = ctrl.retire;
  assign illegal_op  = ctrl.illegal_op;
  assign state       = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
// Directed bench for multicycle_control. A cycle-by-cycle table of
// {OP, mem_ready, expected state, expected control word} walks R, LW (with
// wait states), SW, BEQ, J and an illegal opcode; hand-written sequences
// cover ADDI (MULTICYCLE_CONTROL_ADDI_EN), an asynchronous reset in the
// middle of a load, and a second instance built with MEM_HANDSHAKE=0.
module tb_multicycle_control;
  import cpu_ctrl_pkg::*;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic       mr;
    logic [3:0] st;
    logic [17:0] outs;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (handshake enabled)
  logic       rst, mem_ready;
  logic [5:0] op;
  logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, rd, ret, ill, sa;
  logic [1:0] pcs, aluop, sb;
  logic [3:0] st1;

  // Second instance (handshake disabled, mem_ready held low)
  logic       rst2;
  logic [5:0] op2;
  logic       mem_ready2;
  logic       pcw2, pcwc2, iord2, mrd2, mwr2, irw2, m2r2, rw2, rd2, ret2, ill2, sa2;
  logic [1:0] pcs2, aluop2, sb2;
  logic [3:0] st2;

  multicycle_control #(.MEM_HANDSHAKE(1), .STATE_W(4)) dut (
    .clk(clk), .rst(rst), .OP(op), .mem_ready(mem_ready),
    .PCWrite(pcw), .PCWriteCond(pcwc), .IorD(iord), .MemRead(mrd),
    .MemWrite(mwr), .IRWrite(irw), .MemtoReg(m2r), .PCSource(pcs),
    .ALUop(aluop), .ALUSrcA(sa), .ALUSrcB(sb), .RegWrite(rw),
    .RegDst(rd), .retire(ret), .illegal_op(ill), .state(st1)
  );

  multicycle_control #(.MEM_HANDSHAKE(0), .STATE_W(4)) dut_nh (
    .clk(clk), .rst(rst2), .OP(op2), .mem_ready(mem_ready2),
    .PCWrite(pcw2), .PCWriteCond(pcwc2), .IorD(iord2), .MemRead(mrd2),
    .MemWrite(mwr2), .IRWrite(irw2), .MemtoReg(m2r2), .PCSource(pcs2),
    .ALUop(aluop2), .ALUSrcA(sa2), .ALUSrcB(sb2), .RegWrite(rw2),
    .RegDst(rd2), .retire(ret2), .illegal_op(ill2), .state(st2)
  );

  logic [17:0] outs1, outs2;
  assign outs1 = {pcw, pcwc, iord, mrd, mwr, irw, m2r, pcs, aluop, sa, sb, rw, rd, ret, ill};
  assign outs2 = {pcw2, pcwc2, iord2, mrd2, mwr2, irw2, m2r2, pcs2, aluop2, sa2, sb2, rw2, rd2, ret2, ill2};

  int num_vec  = 0;
  int num_miss = 0;
  vec_t vecs[$];

  logic [17:0] E_ZERO, E_IF1, E_IF0, E_ID, E_IDX, E_MA, E_MRD, E_MWB;
  logic [17:0] E_MWR1, E_MWR0, E_EXE, E_RWB, E_BR, E_JMP, E_AWB;

  // Builds an expected control word in the same bit order as outs1/outs2.
  function automatic logic [17:0] mk(
    input logic f_pcw, f_pcwc, f_iord, f_mrd, f_mwr, f_irw, f_m2r,
    input logic [1:0] f_pcs, f_alu,
    input logic f_sa,
    input logic [1:0] f_sb,
    input logic f_rw, f_rd, f_ret, f_ill);
    return {f_pcw, f_pcwc, f_iord, f_mrd, f_mwr, f_irw, f_m2r, f_pcs, f_alu,
            f_sa, f_sb, f_rw, f_rd, f_ret, f_ill};
  endfunction

  task automatic add(input string n, input logic [5:0] o, input logic m,
                     input logic [3:0] s, input logic [17:0] e);
    vec_t v;
    v.name = n; v.op = o; v.mr = m; v.st = s; v.outs = e;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input bit sel, input logic [5:0] o, input logic m);
    if (sel) begin
      op2 = o;
    end else begin
      op = o;
      mem_ready = m;
    end
  endtask

  task automatic checkOutput(input string n, input bit sel,
                             input logic [3:0] exp_st, input logic [17:0] exp_outs);
    logic [3:0]  got_st;
    logic [17:0] got;
    got_st = sel ? st2 : st1;
    got    = sel ? outs2 : outs1;
    num_vec++;
    if (got_st !== exp_st || got !== exp_outs) begin
      num_miss++;
      $display("[TB] FAIL %s: got state=%0d ctrl=%b, expected state=%0d ctrl=%b",
               n, got_st, got, exp_st, exp_outs);
    end
  endtask

  // Drive inputs just after a rising edge, compare on the falling edge,
  // then advance to just after the next rising edge.
  task automatic runCycle(input string n, input bit sel, input logic [5:0] o,
                          input logic m, input logic [3:0] s, input logic [17:0] e);
    applyStimulus(sel, o, m);
    @(negedge clk);
    checkOutput(n, sel, s, e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            pcw pcwc iord mrd mwr irw m2r pcs    alu    sa sb     rw rd ret ill
    E_ZERO = '0;
    E_IF1  = mk(1, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 2'b01, 0, 0, 0, 0);
    E_IF0  = mk(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 2'b01, 0, 0, 0, 0);
    E_ID   = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b11, 0, 0, 0, 0);
    E_IDX  = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b11, 0, 0, 0, 1);
    E_MA   = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b10, 0, 0, 0, 0);
    E_MRD  = mk(0, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 0);
    E_MWB  = mk(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 2'b00, 1, 0, 1, 0);
    E_MWR1 = mk(0, 0, 1, 0, 1, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 1, 0);
    E_MWR0 = mk(0, 0, 1, 0, 1, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 0);
    E_EXE  = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 1, 2'b00, 0, 0, 0, 0);
    E_RWB  = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 1, 1, 1, 0);
    E_BR   = mk(0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b01, 1, 2'b00, 0, 0, 1, 0);
    E_JMP  = mk(1, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 2'b00, 0, 0, 1, 0);
    E_AWB  = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 1, 0, 1, 0);

    // R-type, 4 cycles (mem_ready low in EXE must be ignored)
    add("r_if",    6'b000000, 1, S_IF,     E_IF1);
    add("r_id",    6'b000000, 1, S_ID,     E_ID);
    add("r_exe",   6'b000000, 0, S_EXE,    E_EXE);
    add("r_rwb",   6'b000000, 1, S_RWB,    E_RWB);
    // LW with two wait cycles in MEMRD, 7 cycles
    add("lw_if",   6'b100011, 1, S_IF,     E_IF1);
    add("lw_id",   6'b100011, 1, S_ID,     E_ID);
    add("lw_adr",  6'b100011, 1, S_MEMADR, E_MA);
    add("lw_rd0",  6'b100011, 0, S_MEMRD,  E_MRD);
    add("lw_rd1",  6'b100011, 0, S_MEMRD,  E_MRD);
    add("lw_rd2",  6'b100011, 1, S_MEMRD,  E_MRD);
    add("lw_wb",   6'b100011, 1, S_MEMWB,  E_MWB);
    // SW, 4 cycles
    add("sw_if",   6'b101011, 1, S_IF,     E_IF1);
    add("sw_id",   6'b101011, 1, S_ID,     E_ID);
    add("sw_adr",  6'b101011, 1, S_MEMADR, E_MA);
    add("sw_wr",   6'b101011, 1, S_MEMWR,  E_MWR1);
    // BEQ, 3 cycles
    add("beq_if",  6'b000100, 1, S_IF,     E_IF1);
    add("beq_id",  6'b000100, 1, S_ID,     E_ID);
    add("beq_br",  6'b000100, 1, S_BR,     E_BR);
    // J, 3 cycles
    add("j_if",    6'b000010, 1, S_IF,     E_IF1);
    add("j_id",    6'b000010, 1, S_ID,     E_ID);
    add("j_jmp",   6'b000010, 1, S_JMP,    E_JMP);
    // Illegal opcode after a fetch wait: pulse in ID, then straight to IF
    add("ill_if0", 6'b111111, 0, S_IF,     E_IF0);
    add("ill_if1", 6'b111111, 1, S_IF,     E_IF1);
    add("ill_id",  6'b111111, 1, S_ID,     E_IDX);
    // SW with one wait cycle in MEMWR, retire only on the accepted cycle
    add("sww_if",  6'b101011, 1, S_IF,     E_IF1);
    add("sww_id",  6'b101011, 1, S_ID,     E_ID);
    add("sww_adr", 6'b101011, 0, S_MEMADR, E_MA);
    add("sww_wr0", 6'b101011, 0, S_MEMWR,  E_MWR0);
    add("sww_wr1", 6'b101011, 1, S_MEMWR,  E_MWR1);
    add("end_if",  6'b000000, 0, S_IF,     E_IF0);

    rst = 1'b1; rst2 = 1'b1;
    op = 6'b000000; op2 = 6'b100011;
    mem_ready = 1'b1; mem_ready2 = 1'b0;

    // Reset state: IF and an all-zero control word even with mem_ready high
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_state", 0, S_IF, E_ZERO);
    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (vecs[i]) begin
      runCycle(vecs[i].name, 0, vecs[i].op, vecs[i].mr, vecs[i].st, vecs[i].outs);
    end

    // ADDI: 4-cycle instruction when enabled, illegal otherwise
`ifdef MULTICYCLE_CONTROL_ADDI_EN
    runCycle("addi_if", 0, 6'b001000, 1, S_IF,     E_IF1);
    runCycle("addi_id", 0, 6'b001000, 1, S_ID,     E_ID);
    runCycle("addi_ex", 0, 6'b001000, 1, S_ADDIEX, E_MA);
    runCycle("addi_wb", 0, 6'b001000, 1, S_ADDIWB, E_AWB);
`else
    runCycle("addi_if", 0, 6'b001000, 1, S_IF, E_IF1);
    runCycle("addi_id", 0, 6'b001000, 1, S_ID, E_IDX);
`endif
    runCycle("addi_next", 0, 6'b000000, 0, S_IF, E_IF0);

    // Reset in the middle of a load: immediate IF, outputs held at zero
    runCycle("rlw_if",  0, 6'b100011, 1, S_IF,     E_IF1);
    runCycle("rlw_id",  0, 6'b100011, 1, S_ID,     E_ID);
    runCycle("rlw_adr", 0, 6'b100011, 1, S_MEMADR, E_MA);
    runCycle("rlw_rd",  0, 6'b100011, 0, S_MEMRD,  E_MRD);
    mem_ready = 1'b1;
    rst = 1'b1;
    #1;
    checkOutput("rst_async", 0, S_IF, E_ZERO);
    @(negedge clk);
    checkOutput("rst_hold_a", 0, S_IF, E_ZERO);
    @(posedge clk);
    #1;
    checkOutput("rst_hold_b", 0, S_IF, E_ZERO);
    rst = 1'b0;
    runCycle("rst_if", 0, 6'b100011, 1, S_IF,     E_IF1);
    runCycle("rst_id", 0, 6'b100011, 1, S_ID,     E_ID);
    runCycle("rst_ad", 0, 6'b100011, 1, S_MEMADR, E_MA);

    // Handshake disabled: LW with mem_ready held low still takes 5 cycles
    rst2 = 1'b0;
    runCycle("nh_if",  1, 6'b100011, 0, S_IF,     E_IF1);
    runCycle("nh_id",  1, 6'b100011, 0, S_ID,     E_ID);
    runCycle("nh_adr", 1, 6'b100011, 0, S_MEMADR, E_MA);
    runCycle("nh_rd",  1, 6'b100011, 0, S_MEMRD,  E_MRD);
    runCycle("nh_wb",  1, 6'b100011, 0, S_MEMWB,  E_MWB);
    runCycle("nh_if2", 1, 6'b101011, 0, S_IF,     E_IF1);

    $display("== %0d vectors applied, %0d miscompares ==", num_vec, num_miss);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle control FSM for the CPU datapath. It supports the same ISA subset as the single-cycle decoder: R-type, LW, SW, BEQ and J.
- It sequences a shared-memory, shared-ALU datapath through fetch, decode, execute, memory and writeback steps.
- It waits on a memory ready handshake during memory steps and issues all datapath enables and mux selects per cycle.

Parameters:
- MEM_HANDSHAKE, 1: 1 means memory states wait for mem_ready; 0 means mem_ready is ignored and treated as constant 1.
- STATE_W, 4: state register width; must hold every state, including the optional ones.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- OP  in  6  opcode, IR[31:26], stable from the cycle after IF completes
- mem_ready  in  1  memory access complete this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if ALU zero
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  writeback data select: 1 = MDR, 0 = ALUOut
- PCSource  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target
- ALUop  out  2  ALU control: 00 = add, 01 = sub, 10 = funct
- ALUSrcA  out  1  ALU operand A: 0 = PC, 1 = A
- ALUSrcB  out  2  ALU operand B: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
- RegWrite  out  1  register file write enable
- RegDst  out  1  destination register: 1 = rd, 0 = rt
- retire  out  1  one-cycle pulse in the final state of each instruction
- illegal_op  out  1  one-cycle pulse in ID when OP is unsupported
- state  out  STATE_W  current state, for debug

Behaviour:
- Reset:
  - rst asserted moves the state asynchronously to IF.
  - While rst is high, every output except state is forced to 0; state reads IF.
  - Reset mid-instruction aborts it: no partial writeback, no retire.
- Outputs are decoded from the state register (Moore), except that the mem_ready qualifiers below are Mealy.
- Unlisted outputs are 0 in every state.
- IF:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=00, PCSource=00.
  - IRWrite and PCWrite equal mem_ready.
  - Stays in IF until mem_ready; then goes to ID.
- ID:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUop=00 (branch target precompute).
  - Decodes OP: 000000 to EXE, 100011 to MEMADR, 101011 to MEMADR, 000100 to BR, 000010 to JMP.
  - Any other OP: illegal_op=1 for this cycle, then back to IF with no retire.
- MEMADR:
  - Outputs: ALUSrcA=1, ALUSrcB=10, ALUop=00.
  - Goes to MEMRD if OP=LW, else MEMWR.
- MEMRD:
  - Outputs: MemRead=1, IorD=1.
  - Holds until mem_ready, then goes to MEMWB.
- MEMWB:
  - Outputs: RegWrite=1, MemtoReg=1, RegDst=0, retire=1.
  - Goes to IF.
- MEMWR:
  - Outputs: MemWrite=1, IorD=1.
  - Holds until mem_ready; retire equals mem_ready; then goes to IF.
- EXE:
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUop=10.
  - Goes to RWB.
- RWB:
  - Outputs: RegWrite=1, RegDst=1, MemtoReg=0, retire=1.
  - Goes to IF.
- BR:
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUop=01, PCWriteCond=1, PCSource=01, retire=1.
  - Goes to IF.
- JMP:
  - Outputs: PCWrite=1, PCSource=10, retire=1.
  - Goes to IF.
- Cycle counts with mem_ready=1: R=4, LW=5, SW=4, BEQ=3, J=3. Each wait cycle adds one.
- The mem_ready input is only sampled in IF, MEMRD and MEMWR; it is ignored elsewhere.
- MemRead and MemWrite are never asserted together. MemRead and MemWrite stay asserted while waiting.
- Unused state encodings recover to IF on the next clock, with all outputs 0 in that cycle.

Optional Feature:
- Macro: MULTICYCLE_CONTROL_ADDI_EN.
- With the macro defined:
  - OP=001000 decodes in ID to ADDIEX.
  - ADDIEX outputs: ALUSrcA=1, ALUSrcB=10, ALUop=00; goes to ADDIWB.
  - ADDIWB outputs: RegWrite=1, RegDst=0, MemtoReg=0, retire=1; goes to IF.
  - ADDI takes 4 cycles.
- Without the macro: OP=001000 is illegal (illegal_op pulse); the ADDIEX and ADDIWB states do not exist.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - opcode constants: OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - state encoding constants
  - ALUop codes
  - PCSource codes
  - ALUSrcB codes
- One natural sub-module: multicycle_control_decode, a combinational state-to-outputs decoder. The parent keeps the state register, next-state logic and reset gating.

Test Plan:
- R-type: OP=000000, mem_ready=1 -> states IF, ID, EXE, RWB; RegWrite=1 and RegDst=1 in cycle 4; retire pulses once.
- LW with wait: OP=100011, mem_ready low 2 cycles in MEMRD -> MEMRD held 3 cycles with MemRead=1, IorD=1; then MEMWB with MemtoReg=1; 7 cycles total.
- SW then BEQ: SW gives MemWrite=1 in cycle 4, no RegWrite. BEQ gives PCWriteCond=1, PCSource=01, ALUop=01 in cycle 3.
- J and illegal: OP=000010 -> PCWrite=1, PCSource=10 in cycle 3. OP=111111 -> illegal_op=1 in ID, back to IF, no retire.
- Reset mid-LW: assert rst in MEMRD -> state=IF immediately; all outputs 0 while rst is high; fetch restarts after release.
- MEM_HANDSHAKE=0 and ADDI macro: mem_ready tied 0 still completes LW in 5 cycles. OP=001000 takes 4 cycles with RegDst=0, ALUSrcB=10.
